// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer between the icache batch read and decode.
// Takes up to FETCH_WIDTH entries per cycle and presents the oldest DECODE_WIDTH in program order.
module fetch_queue #(
  parameter int unsigned FETCH_WIDTH  = 4,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_WIDTH   = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic [FETCH_WIDTH-1:0][WORD_WIDTH-1:0]   in_inst,
  input  logic [ADDR_WIDTH-1:0]                    in_addr,
  input  logic [$clog2(FETCH_WIDTH):0]             in_count,
  output logic                                     in_ready,
  output logic [DECODE_WIDTH-1:0]                  out_valid,
  output logic [DECODE_WIDTH-1:0][WORD_WIDTH-1:0]  out_inst,
  output logic [DECODE_WIDTH-1:0][ADDR_WIDTH-1:0]  out_addr,
  input  logic [$clog2(DECODE_WIDTH):0]            deq_num,
  input  logic                                     flush,
  output logic [$clog2(DEPTH):0]                   count,
  output logic                                     empty,
  output logic                                     full
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned IN_CNT_W = $clog2(FETCH_WIDTH) + 1;
  localparam logic [WORD_WIDTH-1:0] NOP = WORD_WIDTH'(32'h0000_0013);

  logic [WORD_WIDTH-1:0] mem_inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] deq_req;
  logic [CNT_W-1:0] eff_deq;

  // Ready depends only on registered occupancy so upstream sees no combinational loop.
  assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));

  always_comb begin
    enq     = in_valid && in_ready;
    enq_n   = enq ? CNT_W'(in_count) : '0;
    avail   = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
    deq_req = CNT_W'(deq_num);
    eff_deq = (deq_req < avail) ? deq_req : avail;

    head_d  = head_q + PTR_W'(eff_deq);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + enq_n - eff_deq;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; only valid lanes of an accepted, unflushed batch are written.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
        if (IN_CNT_W'(i) < in_count) begin
          mem_inst_q[PTR_W'(tail_q + PTR_W'(i))] <= in_inst[i];
          mem_addr_q[PTR_W'(tail_q + PTR_W'(i))] <= ADDR_WIDTH'(in_addr + ADDR_WIDTH'(i));
        end
      end
    end
  end

  // Oldest entries to decode; empty lanes carry a NOP at index 0.
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_addr  = '0;
    for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
      out_valid[i] = (count_q > CNT_W'(i));
      out_inst[i]  = NOP;
      if (out_valid[i]) begin
        out_inst[i] = mem_inst_q[PTR_W'(head_q + PTR_W'(i))];
        out_addr[i] = mem_addr_q[PTR_W'(head_q + PTR_W'(i))];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: one task per scenario, expectations hand-computed.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [3:0][31:0] in_inst;
  logic [4:0]       in_addr;
  logic [2:0]       in_count;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][4:0]  out_addr;
  logic [1:0]       deq_num;
  logic             flush;
  logic [4:0]       count;
  logic             empty;
  logic             full;

  int checks = 0;
  int errors = 0;

  fetch_queue dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_inst  (in_inst),
    .in_addr  (in_addr),
    .in_count (in_count),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_inst (out_inst),
    .out_addr (out_addr),
    .deq_num  (deq_num),
    .flush    (flush),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_batch(input logic [31:0] base, input logic [4:0] addr, input logic [2:0] n);
    for (int k = 0; k < 4; k++) in_inst[k] = base + 32'(k);
    in_addr  = addr;
    in_count = n;
    in_valid = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    deq_num  = 2'd0;
    flush    = 1'b0;
  endtask

  task automatic clear_queue();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    in_inst = '0; in_addr = '0; in_count = 3'd4;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b exp 00", out_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (out_inst[0] !== NOP || out_inst[1] !== NOP) begin errors++; $display("FAIL reset_nop got %h %h exp %h", out_inst[0], out_inst[1], NOP); end
    checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", out_addr); end
  endtask

  task automatic test_enq_deq();
    set_batch(32'hA000_0000, 5'd8, 3'd4);
    step();
    in_valid = 1'b0;
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL enq_count got %0d exp 4", count); end
    checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL enq_valid got %b exp 11", out_valid); end
    checks++; if (out_inst[0] !== 32'hA000_0000 || out_inst[1] !== 32'hA000_0001) begin errors++; $display("FAIL enq_inst got %h %h exp A0000000 A0000001", out_inst[0], out_inst[1]); end
    checks++; if (out_addr[0] !== 5'd8 || out_addr[1] !== 5'd9) begin errors++; $display("FAIL enq_addr got %0d %0d exp 8 9", out_addr[0], out_addr[1]); end
    deq_num = 2'd2;
    step();
    deq_num = 2'd0;
    checks++; if (out_inst[0] !== 32'hA000_0002 || out_inst[1] !== 32'hA000_0003) begin errors++; $display("FAIL deq_inst got %h %h exp A0000002 A0000003", out_inst[0], out_inst[1]); end
    checks++; if (out_addr[0] !== 5'd10 || out_addr[1] !== 5'd11) begin errors++; $display("FAIL deq_addr got %0d %0d exp 10 11", out_addr[0], out_addr[1]); end
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL deq_count got %0d exp 2", count); end
  endtask

  task automatic test_fill();
    clear_queue();
    for (int b = 0; b < 4; b++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1 at count %0d", b, in_ready, count); end
      set_batch(32'hB000_0000 + 32'(4*b), 5'(4*b), 3'd4);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 5'd16 || in_ready !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL fill_full got count=%0d ready=%b full=%b exp 16/0/1", count, in_ready, full); end
    set_batch(32'hDEAD_0000, 5'd0, 3'd4);
    step();
    in_valid = 1'b0;
    checks++; if (count !== 5'd16 || out_inst[0] !== 32'hB000_0000) begin errors++; $display("FAIL fill_reject got count=%0d inst=%h exp 16 B0000000", count, out_inst[0]); end
    deq_num = 2'd2;
    step(); step();
    checks++; if (count !== 5'd12 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_at12 got count=%0d ready=%b exp 12/1", count, in_ready); end
    set_batch(32'hC000_0000, 5'd16, 3'd4);
    step();
    in_valid = 1'b0;
    deq_num  = 2'd0;
    checks++; if (count !== 5'd14) begin errors++; $display("FAIL fill_enqdeq_count got %0d exp 14", count); end
    checks++; if (out_inst[0] !== 32'hB000_0006 || out_addr[0] !== 5'd6) begin errors++; $display("FAIL fill_order got %h @%0d exp B0000006 @6", out_inst[0], out_addr[0]); end
  endtask

  task automatic test_wrap_partial();
    clear_queue();
    set_batch(32'h1000_0000, 5'd0, 3'd4); step();
    set_batch(32'h1000_0000, 5'd0, 3'd4); step();
    set_batch(32'h1000_0000, 5'd0, 3'd4); step();
    set_batch(32'h1000_0000, 5'd0, 3'd2); step();
    in_valid = 1'b0;
    deq_num  = 2'd2;
    for (int k = 0; k < 7; k++) step();
    deq_num = 2'd0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_setup got count %0d exp 0", count); end
    set_batch(32'hD000_0000, 5'd30, 3'd3);
    step();
    in_valid = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", count); end
    checks++; if (out_inst[0] !== 32'hD000_0000 || out_inst[1] !== 32'hD000_0001 || out_addr[0] !== 5'd30 || out_addr[1] !== 5'd31) begin errors++; $display("FAIL wrap_first got %h@%0d %h@%0d exp D0000000@30 D0000001@31", out_inst[0], out_addr[0], out_inst[1], out_addr[1]); end
    deq_num = 2'd2;
    step();
    deq_num = 2'd0;
    checks++; if (out_valid !== 2'b01 || out_inst[0] !== 32'hD000_0002 || out_addr[0] !== 5'd0) begin errors++; $display("FAIL wrap_second got v=%b %h@%0d exp 01 D0000002@0", out_valid, out_inst[0], out_addr[0]); end
    checks++; if (out_inst[1] !== NOP || out_addr[1] !== 5'd0) begin errors++; $display("FAIL wrap_lane3 got %h@%0d exp %h@0", out_inst[1], out_addr[1], NOP); end
  endtask

  task automatic test_over_deq();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL over_setup got count %0d exp 1", count); end
    deq_num = 2'd2;
    step();
    deq_num = 2'd0;
    checks++; if (count !== 5'd0 || out_valid !== 2'b00 || empty !== 1'b1) begin errors++; $display("FAIL over_deq got count=%0d v=%b empty=%b exp 0/00/1", count, out_valid, empty); end
  endtask

  task automatic test_flush();
    set_batch(32'hE000_0000, 5'd0, 3'd4); step();
    set_batch(32'hE000_0004, 5'd4, 3'd2); step();
    in_valid = 1'b0;
    checks++; if (count !== 5'd6) begin errors++; $display("FAIL flush_setup got count %0d exp 6", count); end
    set_batch(32'hE000_0010, 5'd16, 3'd4);
    deq_num = 2'd2;
    flush   = 1'b1;
    step();
    idle_inputs();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || in_ready !== 1'b1 || out_valid !== 2'b00) begin errors++; $display("FAIL flush_state got count=%0d empty=%b ready=%b v=%b exp 0/1/1/00", count, empty, in_ready, out_valid); end
    set_batch(32'hE000_0020, 5'd20, 3'd4);
    step();
    in_valid = 1'b0;
    checks++; if (count !== 5'd4 || out_inst[0] !== 32'hE000_0020 || out_addr[0] !== 5'd20) begin errors++; $display("FAIL flush_after got count=%0d %h@%0d exp 4 E0000020@20", count, out_inst[0], out_addr[0]); end
  endtask

  task automatic test_back_to_back();
    clear_queue();
    deq_num = 2'd2;
    set_batch(32'hF000_0000, 5'd0, 3'd4); step();
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL b2b_c1 got %0d exp 4", count); end
    set_batch(32'hF000_0004, 5'd4, 3'd4); step();
    checks++; if (count !== 5'd6 || out_inst[0] !== 32'hF000_0002) begin errors++; $display("FAIL b2b_c2 got count=%0d %h exp 6 F0000002", count, out_inst[0]); end
    set_batch(32'hF000_0008, 5'd8, 3'd4); step();
    idle_inputs();
    checks++; if (count !== 5'd8 || out_inst[0] !== 32'hF000_0004 || out_addr[0] !== 5'd4 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_c3 got count=%0d %h@%0d ready=%b exp 8 F0000004@4 1", count, out_inst[0], out_addr[0], in_ready); end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || out_valid !== 2'b00 || out_inst[0] !== NOP) begin errors++; $display("FAIL async_rst got count=%0d empty=%b v=%b inst=%h exp 0/1/00/%h", count, empty, out_valid, out_inst[0], NOP); end
    step();
    rst = 1'b0;
    step();
    checks++; if (count !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_release got count=%0d ready=%b exp 0/1", count, in_ready); end
  endtask

  initial begin
    test_reset();
    test_enq_deq();
    test_fill();
    test_wrap_partial();
    test_over_deq();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the icache batch read and decode. Accepts up to FETCH_WIDTH instructions per cycle from the icache output batch, each tagged with its absolute instruction index. Presents the oldest DECODE_WIDTH entries to decode in program order. Absorbs rate mismatch, decode back-pressure and front-end flushes.

## Interface
Parameters:
- FETCH_WIDTH, 4, instructions per enqueue batch (matches icache batch width)
- DECODE_WIDTH, 2, instructions presented per cycle to decode
- WORD_WIDTH, 32, instruction width
- DEPTH, 16, queue entries; power of two, ≥ FETCH_WIDTH + DECODE_WIDTH
- ADDR_WIDTH, 5, instruction index width (same as icache fetch_addr)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  batch present
- in_inst  in  [FETCH_WIDTH][WORD_WIDTH]  batch; lane 0 oldest
- in_addr  in  ADDR_WIDTH  index of lane 0
- in_count  in  $clog2(FETCH_WIDTH)+1  valid lanes, 1..FETCH_WIDTH, contiguous from lane 0
- in_ready  out  1  queue can take a full batch
- out_valid  out  DECODE_WIDTH  bit i set iff count > i (thermometer)
- out_inst  out  [DECODE_WIDTH][WORD_WIDTH]  oldest entries, lane 0 oldest
- out_addr  out  [DECODE_WIDTH][ADDR_WIDTH]  index of each out lane
- deq_num  in  $clog2(DECODE_WIDTH)+1  entries decode consumes this cycle
- flush  in  1  discard all contents
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Circular buffer: head (read) and tail (write) pointers, $clog2(DEPTH) bits, wrapping modulo DEPTH. Plus a registered count. Each entry holds inst and addr.
- Enqueue fires when in_valid && in_ready. Lane i < in_count is written to slot (tail+i) mod DEPTH with addr (in_addr+i) mod 2^ADDR_WIDTH. Tail advances by in_count. Lanes ≥ in_count are ignored, which lets upstream drop icache out-of-range NOP padding.
- in_valid while in_ready=0 is ignored; upstream must hold the batch.
- in_ready = (DEPTH − count) ≥ FETCH_WIDTH. It is a function of registered count only, with no path from in_valid/in_count/deq_num.
- Dequeue: eff_deq = min(deq_num, number of set out_valid bits); excess is clipped silently. Head advances by eff_deq.
- out lane i = entry (head+i) mod DEPTH, driven combinationally from storage. When out_valid[i]=0, out_inst[i]=32'h00000013 (NOP) and out_addr[i]=0.
- Simultaneous enq+deq: count_next = count + enq_n − eff_deq.
- flush: head, tail and count are set to 0 at the next edge. A same-cycle enqueue and dequeue are both discarded. Flush has priority over everything except rst.
- Storage contents are not reset; only pointers and count are.

## Timing
- Reset (async assert, value held while rst=1): head=tail=count=0, so out_valid=0, empty=1, full=0, in_ready=1, out_inst=NOP, out_addr=0.
- Reset mid-operation: all state clears immediately without waiting for a clock edge. Contents are lost.
- Enqueue-to-output latency: 1 cycle. A batch accepted at edge N is visible on out_* after edge N. There is no same-cycle bypass when empty.
- Dequeue takes effect at the edge. The next entries appear in the following cycle.
- Throughput: sustained FETCH_WIDTH in / DECODE_WIDTH out per cycle, limited by in_ready.
- Pointer wrap from DEPTH−1 to 0 preserves program order. Address wrap from 2^ADDR_WIDTH−1 to 0 is modular.
- count, full and empty are registered-derived and glitch-free relative to inputs.

## Test plan
- Reset then idle: in_ready=1, out_valid=2'b00, count=0, empty=1, out_inst=NOP on both lanes.
- Enqueue A0..A3, in_addr=8, in_count=4, deq_num=0: next cycle count=4, out_inst={A0,A1}, out_addr={8,9}. Then deq_num=2: next cycle out={A2,A3}, addr={10,11}, count=2.
- Fill without dequeue (4 full batches): in_ready=1 at count=12, 0 at count=16, full=1. A further in_valid is ignored and count stays 16. Then enqueue 4 with deq_num=2 at count=12: count=14.
- Wrap and partial batch: in_addr=30, in_count=3, with the head near slot 15. Outputs read in order with addr 30, 31, 0 across the pointer wrap. Lane 3 is not stored.
- Over-dequeue: count=1, deq_num=2: eff_deq=1, count=0, out_valid=00.
- Flush with concurrent enqueue and deq_num=2 at count=6: next cycle count=0, empty=1, in_ready=1. Async rst asserted mid-batch clears state before the next edge.
